ram_arbiter_2port: RTL and testbench

- Shares one 256x8 single-port RAM (RAM_8BIT interface: address, write_enable, write_data, read_enable, read_data) between two requesters.
- Arbitrates requests, sequences each RAM access and returns a completion/read-data response to the owning requester.
- Sits between client logic (e.g. a DMA-style engine and a CPU-style master) and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 25 ++
 rtl/ram_arbiter_2port.sv | 112 +++++++++++
 tb/tb_ram_arbiter_2port.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, default widths and latched command type for ram_arbiter_2port
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  owner;
    } cmd_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; RAM_ARB_FIXED_PRI_EN switches to fixed priority for requester 0
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
`ifdef RAM_ARB_FIXED_PRI_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clock, reset, accept};
    assign grant = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    logic last_grant_q, last_grant_d;
    always_comb begin
        grant = (&req) ? (last_grant_q ? 2'b01 : 2'b10) : req;
        last_grant_d = accept ? grant[1] : last_grant_q;
    end
    // last_grant_q resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif
endmodule

// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port: shares one single-port RAM between two requesters (RAM_ARB_FIXED_PRI_EN = fixed priority)
module ram_arbiter_2port
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enable,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_read_data
);
    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic [1:0]        req, grant;
    logic              accept;

    assign req    = {req1_valid, req0_valid};
    assign accept = (state_q == IDLE) && !reset && (|req);

    rr_arbiter_2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign ram_address    = cmd_q.addr;
    assign ram_write_data = cmd_q.wdata;
    assign rsp0_valid     = rsp_valid_q[0];
    assign rsp1_valid     = rsp_valid_q[1];
    assign rsp0_rdata     = rsp0_rdata_q;
    assign rsp1_rdata     = rsp1_rdata_q;

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        rsp_valid_d      = 2'b00;
        rsp0_rdata_d     = rsp0_rdata_q;
        rsp1_rdata_d     = rsp1_rdata_q;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        ram_write_enable = 1'b0;
        ram_read_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    cmd_d      = grant[1] ? '{req1_write, req1_addr, req1_wdata, 1'b1}
                                          : '{req0_write, req0_addr, req0_wdata, 1'b0};
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // a reset landing on the access cycle must not touch the RAM
                ram_write_enable = cmd_q.write && !reset;
                ram_read_enable  = !cmd_q.write && !reset;
                if (cmd_q.write) begin
                    rsp_valid_d[cmd_q.owner] = 1'b1;
                    state_d                  = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_valid_d[cmd_q.owner] = 1'b1;
                rsp0_rdata_d = cmd_q.owner ? rsp0_rdata_q : ram_read_data;
                rsp1_rdata_d = cmd_q.owner ? ram_read_data : rsp1_rdata_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// tb_ram_arbiter_2port: directed and random traffic checked against a transaction-level model
`timescale 1ns/1ps
module tb_ram_arbiter_2port;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rv = 2'b00, rw = 2'b00;
    logic [7:0] ra [2];
    logic [7:0] rd [2];
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata, ram_address, ram_write_data, ram_read_data;
    logic       ram_write_enable, ram_read_enable;
    logic [7:0] mem [256];
    int         checks = 0, errors = 0;

    logic [7:0] ref_mem [256];
    int         cyc = 0, free_at = 0, p_c = -100;
    bit         p_w = 1'b0, p_o = 1'b0, last = 1'b1;
    logic [7:0] p_a = 8'h00, p_d = 8'h00, exp_addr = 8'h00, exp_wd = 8'h00;
    logic [7:0] exp_rd [2];
    logic [1:0] acc = 2'b00;

    always #5 clock = ~clock;

    ram_arbiter_2port dut (
        .clock(clock), .reset(reset),
        .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_write(rw[0]),
        .req0_addr(ra[0]), .req0_wdata(rd[0]), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_write(rw[1]),
        .req1_addr(ra[1]), .req1_wdata(rd[1]), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data), .ram_read_enable(ram_read_enable),
        .ram_read_data(ram_read_data)
    );

    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_address] <= ram_write_data;
        if (ram_read_enable) ram_read_data <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] g, ev;
        logic       ewe, ere;
        int         w;
        @(negedge clock);
        g = 2'b00;
        if (!reset && cyc >= free_at && rv != 2'b00) begin
`ifdef RAM_ARB_FIXED_PRI_EN
            w = rv[0] ? 0 : 1;
`else
            w = (rv == 2'b11) ? int'(!last) : int'(rv[1]);
`endif
            g[w] = 1'b1;
        end
        ewe = !reset && cyc == p_c + 1 && p_w;
        ere = !reset && cyc == p_c + 1 && !p_w;
        ev  = 2'b00;
        if (cyc == p_c + (p_w ? 2 : 3)) begin
            ev[p_o] = 1'b1;
            if (!p_w) exp_rd[p_o] = ref_mem[p_a];
        end
        chk("req0_ready", req0_ready, g[0]);
        chk("req1_ready", req1_ready, g[1]);
        chk("ram_write_enable", ram_write_enable, ewe);
        chk("ram_read_enable", ram_read_enable, ere);
        chk("ram_address", ram_address, exp_addr);
        chk("ram_write_data", ram_write_data, exp_wd);
        chk("rsp0_valid", rsp0_valid, ev[0]);
        chk("rsp1_valid", rsp1_valid, ev[1]);
        chk("rsp0_rdata", rsp0_rdata, exp_rd[0]);
        chk("rsp1_rdata", rsp1_rdata, exp_rd[1]);
        acc = g;
        if (reset) begin
            p_c = -100; free_at = 0; last = 1'b1;
            exp_addr = 8'h00; exp_wd = 8'h00; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        end else begin
            if (ewe) ref_mem[p_a] = p_d;
            if (g != 2'b00) begin
                w = int'(g[1]);
                p_c = cyc; p_w = rw[w]; p_o = g[1]; p_a = ra[w]; p_d = rd[w];
                free_at = cyc + (p_w ? 2 : 3);
                last = g[1];
                exp_addr = p_a; exp_wd = p_d;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        rv = rv & ~acc;
    endtask

    task automatic issue(input int o, input bit w, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        rv[o] = 1'b1; rw[o] = w; ra[o] = a; rd[o] = d;
        while (rv[o] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (!rv[o]) else begin
            errors++;
            $error("FAIL accept_timeout observed pending expected accepted");
            rv[o] = 1'b0;
        end
    endtask

    initial begin
        int n, k;
        logic [5:0] order;
        logic [7:0] save1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ra[0] = 8'h00; ra[1] = 8'h00; rd[0] = 8'h00; rd[1] = 8'h00;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        ram_read_data = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        tick();
        tick();
        reset = 1'b0;

        issue(0, 1'b1, 8'h07, 8'hDA);
        issue(0, 1'b0, 8'h07, 8'h00);
        repeat (3) tick();
        chk("wr_rd_rdata0", rsp0_rdata, 8'hDA);
        chk("wr_rd_rdata1", rsp1_rdata, 8'h00);

        reset = 1'b1; tick(); reset = 1'b0;
        rv = 2'b11; rw = 2'b11;
        ra[0] = 8'h10; rd[0] = 8'h11; ra[1] = 8'h20; rd[1] = 8'h22;
        tick();
        chk("sim_first_grant", {6'b0, acc}, 8'h01);
        n = 0;
        while (rv[1] && n < 10) begin
            tick();
            n++;
        end
        chk("sim_second_delay", 8'(n), 8'd2);
        issue(0, 1'b0, 8'h10, 8'h00);
        issue(1, 1'b0, 8'h20, 8'h00);
        repeat (4) tick();
        chk("sim_readback0", rsp0_rdata, 8'h11);
        chk("sim_readback1", rsp1_rdata, 8'h22);

        reset = 1'b1; tick(); reset = 1'b0;
        rw = 2'b00; ra[0] = 8'h07; ra[1] = 8'h10;
        rv = 2'b11; n = 0; k = 0; order = 6'b0;
        while (k < 6 && n < 40) begin
            tick();
            n++;
            if (acc != 2'b00) begin
                order[k] = acc[1];
                k++;
            end
            rv = 2'b11;
        end
        rv = 2'b00;
        chk("rr_grant_count", 8'(k), 8'd6);
`ifdef RAM_ARB_FIXED_PRI_EN
        chk("rr_order", {2'b0, order}, 8'h00);
`else
        chk("rr_order", {2'b0, order}, 8'h2A);
`endif
        repeat (4) tick();

        save1 = exp_rd[1];
        issue(1, 1'b1, 8'hFF, 8'hA5);
        issue(0, 1'b0, 8'hFF, 8'h00);
        repeat (3) tick();
        chk("cross_rdata0", rsp0_rdata, 8'hA5);
        chk("cross_rdata1", rsp1_rdata, save1);

        issue(0, 1'b0, 8'h07, 8'h00);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_rdata0", rsp0_rdata, 8'h00);
        chk("rst_rsp0_valid", {7'b0, rsp0_valid}, 8'h00);
        chk("rst_enables", {6'b0, ram_write_enable, ram_read_enable}, 8'h00);
        issue(0, 1'b0, 8'h07, 8'h00);
        repeat (3) tick();
        chk("after_rst_rdata0", rsp0_rdata, 8'hDA);

        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 8'h20;
        issue(0, 1'b1, 8'h30, 8'h77);
        n = 0;
        while (rv[1] && n < 10) begin
            tick();
            n++;
        end
        chk("hold_req1_served", {7'b0, rv[1]}, 8'h00);
        repeat (4) tick();

        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int o = 0; o < 2; o++) begin
                if (!rv[o] && $urandom_range(0, 2) != 0) begin
                    rv[o] = 1'b1;
                    rw[o] = 1'($urandom_range(0, 1));
                    ra[o] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                    rd[o] = 8'($urandom_range(0, 255));
                end
            end
            tick();
        end
        reset = 1'b0;
        rv = 2'b00;
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
